dcpu16_mcalu: RTL and testbench

DCPU16_MCALU -- requirements
Module: dcpu16_mcalu

---
 rtl/dcpu16_mcalu.sv | 151 +++++++++++++++
 tb/tb_dcpu16_mcalu.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/dcpu16_mcalu.sv
// dcpu16_mcalu: DCPU-16 style ALU with single-cycle ops and an iterative restoring divider for DIV/MOD.
module dcpu16_mcalu #(
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ena,
    input  logic [3:0]    opc,
    input  logic [DW-1:0] src,
    input  logic [DW-1:0] tgt,
    output logic [DW-1:0] regR,
    output logic [DW-1:0] regO,
    output logic          regF,
    output logic          busy,
    output logic          done
);
    localparam int CW = $clog2(2*DW+1);
    localparam logic [CW-1:0] LAST_DIV = CW'(2*DW-1);
    localparam logic [CW-1:0] LAST_MOD = CW'(DW-1);
    localparam logic [3:0] OP_SET = 4'h1, OP_ADD = 4'h2, OP_SUB = 4'h3, OP_MUL = 4'h4,
                           OP_DIV = 4'h5, OP_MOD = 4'h6, OP_SHL = 4'h7, OP_SHR = 4'h8,
                           OP_AND = 4'h9, OP_BOR = 4'hA, OP_XOR = 4'hB, OP_IFE = 4'hC,
                           OP_IFN = 4'hD, OP_IFG = 4'hE, OP_IFB = 4'hF;

    typedef enum logic [1:0] {IDLE, DIVI, FIN} state_t;

    state_t            state_q, state_d;
    logic [DW-1:0]     r_q, r_d, o_q, o_d, b_q, b_d;
    logic              f_q, f_d, done_q, done_d, mod_q, mod_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [DW:0]       rem_q, rem_d, rem_sh, rem_s;
    logic [2*DW-1:0]   quo_q, quo_d, quo_s;
    logic [2*DW-1:0]   mul_w, shl_w, shr_w;
    logic [DW:0]       add_w;
    logic              fit;

    // One restoring step: dividend bits leave the top of quo as quotient bits enter the bottom.
    always_comb begin
        rem_sh = {rem_q[DW-1:0], quo_q[2*DW-1]};
        fit    = rem_sh >= {1'b0, b_q};
        rem_s  = fit ? rem_sh - {1'b0, b_q} : rem_sh;
        quo_s  = {quo_q[2*DW-2:0], fit};
        mul_w  = {{DW{1'b0}}, src} * {{DW{1'b0}}, tgt};
        shl_w  = {{DW{1'b0}}, src} << tgt;
        shr_w  = {src, {DW{1'b0}}} >> tgt;
        add_w  = {1'b0, src} + {1'b0, tgt};
    end

    always_comb begin
        state_d = (state_q == FIN) ? IDLE : state_q;
        r_d     = r_q;
        o_d     = o_q;
        f_d     = f_q;
        b_d     = b_q;
        mod_d   = mod_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        done_d  = 1'b0;
        if (state_q == DIVI) begin
            rem_d = rem_s;
            quo_d = quo_s;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == (mod_q ? LAST_MOD : LAST_DIV)) begin
                state_d = FIN;
                done_d  = 1'b1;
                r_d     = mod_q ? rem_s[DW-1:0] : quo_s[2*DW-1:DW];
                o_d     = mod_q ? o_q : quo_s[DW-1:0];
            end
        end else if (ena) begin
            done_d = 1'b1;
            case (opc)
                OP_SET: r_d = tgt;
                OP_ADD: begin
                    r_d = add_w[DW-1:0];
                    o_d = {{(DW-1){1'b0}}, add_w[DW]};
                end
                OP_SUB: begin
                    r_d = src - tgt;
                    o_d = (src < tgt) ? '1 : '0;
                end
                OP_MUL: begin
                    r_d = mul_w[DW-1:0];
                    o_d = mul_w[2*DW-1:DW];
                end
                OP_DIV, OP_MOD: begin
                    if (tgt != '0) begin
                        state_d = DIVI;
                        done_d  = 1'b0;
                        b_d     = tgt;
                        mod_d   = (opc == OP_MOD);
                        cnt_d   = '0;
                        rem_d   = '0;
                        quo_d   = {src, {DW{1'b0}}};
                    end else begin
                        r_d = '0;
                        o_d = (opc == OP_DIV) ? '0 : o_q;
                    end
                end
                OP_SHL: begin
                    r_d = shl_w[DW-1:0];
                    o_d = shl_w[2*DW-1:DW];
                end
                OP_SHR: begin
                    r_d = shr_w[2*DW-1:DW];
                    o_d = shr_w[DW-1:0];
                end
                OP_AND: r_d = src & tgt;
                OP_BOR: r_d = src | tgt;
                OP_XOR: r_d = src ^ tgt;
                OP_IFE: f_d = (src == tgt);
                OP_IFN: f_d = (src != tgt);
                OP_IFG: f_d = (src > tgt);
                OP_IFB: f_d = ((src & tgt) != '0);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            r_q     <= '0;
            o_q     <= '0;
            f_q     <= 1'b0;
            b_q     <= '0;
            mod_q   <= 1'b0;
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            o_q     <= o_d;
            f_q     <= f_d;
            b_q     <= b_d;
            mod_q   <= mod_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            done_q  <= done_d;
        end
    end

    assign regR = r_q;
    assign regO = o_q;
    assign regF = f_q;
    assign busy = (state_q == DIVI);
    assign done = done_q;
endmodule

// File: tb/tb_dcpu16_mcalu.sv
// tb_dcpu16_mcalu: directed checks of dcpu16_mcalu at DW=16 with hand-computed expectations.
module tb_dcpu16_mcalu;
    logic        clk, rst, ena, regF, busy, done;
    logic [3:0]  opc;
    logic [15:0] src, tgt, regR, regO;
    int          passed = 0, fails = 0, total = 0;
    int          lat, bcnt, leak, n, dcnt;

    dcpu16_mcalu #(.DW(16)) dut (
        .clk(clk), .rst(rst), .ena(ena), .opc(opc), .src(src), .tgt(tgt),
        .regR(regR), .regO(regO), .regF(regF), .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge: issues one request and waits (bounded) for done.
    task automatic run(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        logic [15:0] r0, o0;
        r0 = regR; o0 = regO;
        opc = op; src = a; tgt = b; ena = 1'b1;
        lat = 0; bcnt = 0; leak = 0;
        do begin
            @(negedge clk);
            ena = 1'b0;
            lat++;
            if (busy) begin
                bcnt++;
                if (regR !== r0 || regO !== o0) leak++;
            end
        end while (!done && lat < 100);
    endtask

    initial begin
        rst = 1'b0; ena = 1'b0; opc = 4'h0; src = '0; tgt = '0;
        #2;
        chk("reset_state", {regR, regO, regF, busy, done}, 35'h0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        run(4'h2, 16'hFFFF, 16'h0002);
        chk("add_carry", {lat, regR, regO}, {32'd1, 16'h0001, 16'h0001});
        run(4'h1, 16'h1234, 16'h5555);
        chk("set_keeps_o", {regR, regO}, {16'h5555, 16'h0001});
        run(4'h3, 16'h0001, 16'h0002);
        chk("sub_borrow", {regR, regO}, {16'hFFFF, 16'hFFFF});
        run(4'h3, 16'h0005, 16'h0003);
        chk("sub_plain", {regR, regO}, {16'h0002, 16'h0000});
        run(4'h4, 16'h1000, 16'h0100);
        chk("mul", {regR, regO}, {16'h0000, 16'h0010});
        run(4'h8, 16'h1234, 16'h0004);
        chk("shr", {regR, regO}, {16'h0123, 16'h4000});
        run(4'h7, 16'h8001, 16'h0001);
        chk("shl", {regR, regO}, {16'h0002, 16'h0001});
        run(4'h7, 16'h0003, 16'h0011);
        chk("shl_ge_dw", {regR, regO}, {16'h0000, 16'h0006});
        run(4'h8, 16'hFFFF, 16'h0020);
        chk("shr_ge_2dw", {regR, regO}, {16'h0000, 16'h0000});
        run(4'h4, 16'h0003, 16'h0011);
        run(4'h7, 16'hFFFF, 16'h0020);
        chk("shl_ge_2dw", {regR, regO}, {16'h0000, 16'h0000});

        run(4'h4, 16'hAA00, 16'h0100);
        chk("mul_hi", {regR, regO}, {16'h0000, 16'h00AA});
        run(4'hB, 16'hF0F0, 16'h0FF0);
        chk("xor", {regR, regO}, {16'hFF00, 16'h00AA});
        run(4'h9, 16'hF0F0, 16'h0FF0);
        chk("and", {regR, regO}, {16'h00F0, 16'h00AA});
        run(4'hA, 16'hF000, 16'h000F);
        chk("bor", {regR, regO}, {16'hF00F, 16'h00AA});

        run(4'hC, 16'h0005, 16'h0005);
        chk("ife", {regF, regR, regO}, {1'b1, 16'hF00F, 16'h00AA});
        run(4'hD, 16'h0005, 16'h0005);
        chk("ifn", {regF, regR}, {1'b0, 16'hF00F});
        run(4'hE, 16'h0003, 16'h0002);
        chk("ifg", regF, 1'b1);
        run(4'hB, 16'h0001, 16'h0001);
        chk("xor_keeps_f", {regF, regR, regO}, {1'b1, 16'h0000, 16'h00AA});
        run(4'hF, 16'h0001, 16'h0002);
        chk("ifb_zero", regF, 1'b0);
        run(4'hE, 16'h8000, 16'h7FFF);
        chk("ifg_unsigned", regF, 1'b1);
        run(4'h0, 16'hFFFF, 16'hFFFF);
        chk("nop", {lat, regF, regR, regO}, {32'd1, 1'b1, 16'h0000, 16'h00AA});

        opc = 4'h2; src = 16'h0001; tgt = 16'h0001; ena = 1'b1;
        @(negedge clk);
        chk("b2b_first", {done, busy, regR}, {1'b1, 1'b0, 16'h0002});
        src = 16'h0002; tgt = 16'h0002;
        @(negedge clk);
        ena = 1'b0;
        chk("b2b_second", {done, busy, regR}, {1'b1, 1'b0, 16'h0004});

        run(4'h5, 16'h0007, 16'h0002);
        chk("div_timing", {lat, bcnt, leak}, {32'd33, 32'd32, 32'd0});
        chk("div_result", {regR, regO}, {16'h0003, 16'h8000});
        run(4'h6, 16'h0007, 16'h0002);
        chk("mod_timing", {lat, bcnt, leak}, {32'd17, 32'd16, 32'd0});
        chk("mod_result", {regR, regO}, {16'h0001, 16'h8000});
        run(4'h5, 16'hFFFF, 16'h0001);
        chk("div_max", {regR, regO}, {16'hFFFF, 16'h0000});
        run(4'h5, 16'h1234, 16'h0000);
        chk("div_by0", {lat, regR, regO}, {32'd1, 16'h0000, 16'h0000});
        run(4'h4, 16'hAA00, 16'h0100);
        run(4'h6, 16'h0005, 16'h0000);
        chk("mod_by0", {lat, regR, regO}, {32'd1, 16'h0000, 16'h00AA});

        opc = 4'h5; src = 16'h0007; tgt = 16'h0002; ena = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            ena = (n == 4);
            if (n == 4) begin
                opc = 4'h2; src = 16'hFFFF; tgt = 16'h0002;
            end
        end while (!done && n < 100);
        chk("div_ignore_ena", {n, regR, regO}, {32'd33, 16'h0003, 16'h8000});
        opc = 4'h2; src = 16'h0001; tgt = 16'h0001; ena = 1'b1;
        @(negedge clk);
        ena = 1'b0;
        chk("add_in_fin", {done, regR, regO}, {1'b1, 16'h0002, 16'h0000});

        opc = 4'h5; src = 16'h0007; tgt = 16'h0002; ena = 1'b1;
        @(negedge clk);
        ena = 1'b0;
        repeat (9) @(negedge clk);
        chk("pre_reset_busy", busy, 1'b1);
        #2 rst = 1'b0;
        #1 chk("async_reset", {regR, regO, regF, busy, done}, 35'h0);
        @(negedge clk);
        rst = 1'b1;
        dcnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (done || busy) dcnt++;
        end
        chk("no_done_after_abort", dcnt, 0);
        run(4'hE, 16'h0003, 16'h0002);
        chk("ifg_after_reset", {lat, regF, regR, regO}, {32'd1, 1'b1, 16'h0000, 16'h0000});

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
